// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: RAM pins, LSB request port and ICache fill port.
// master = arbiter side, slave = LSB/ICache/RAM environment side.
interface mem_arbiter_if #(
  parameter int LINE_BYTES = 16
);
  localparam int IW = $clog2(LINE_BYTES);

  logic [7:0]    mem_din;
  logic [7:0]    mem_dout;
  logic [31:0]   mem_a;
  logic          mem_wr;
  logic          io_buffer_full;
  logic          flush_in;

  logic          lsb_req;
  logic          lsb_wr;
  logic [31:0]   lsb_addr;
  logic [1:0]    lsb_size;
  logic          lsb_signed;
  logic [31:0]   lsb_wdata;
  logic          lsb_done;
  logic [31:0]   lsb_rdata;

  logic          ic_req;
  logic [31:0]   ic_addr;
  logic [7:0]    ic_byte;
  logic          ic_byte_valid;
  logic [IW-1:0] ic_byte_idx;
  logic          ic_done;

  modport master (
    input  mem_din, io_buffer_full, flush_in,
    input  lsb_req, lsb_wr, lsb_addr, lsb_size,
    input  lsb_signed, lsb_wdata,
    input  ic_req, ic_addr,
    output mem_dout, mem_a, mem_wr,
    output lsb_done, lsb_rdata,
    output ic_byte, ic_byte_valid, ic_byte_idx, ic_done
  );

  modport slave (
    output mem_din, io_buffer_full, flush_in,
    output lsb_req, lsb_wr, lsb_addr, lsb_size,
    output lsb_signed, lsb_wdata,
    output ic_req, ic_addr,
    input  mem_dout, mem_a, mem_wr,
    input  lsb_done, lsb_rdata,
    input  ic_byte, ic_byte_valid, ic_byte_idx, ic_done
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: byte-serial sequencer for the 8-bit main RAM port.
// Orders LSB loads/stores and ICache line fills, LSB first.
module mem_arbiter #(
  parameter int LINE_BYTES = 16
) (
  input logic           clk_in,
  input logic           rst_in,
  mem_arbiter_if.master bus
);
  localparam int IW = $clog2(LINE_BYTES);
  localparam int CW = IW + 1;
  localparam logic [CW-1:0] LINE_CNT = CW'(LINE_BYTES);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_LSB_RD  = 2'd1;
  localparam logic [1:0] S_LSB_WR  = 2'd2;
  localparam logic [1:0] S_IC_FILL = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] nbytes_q, nbytes_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   buf_q, buf_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          signed_q, signed_d;
  logic          lsb_done_q, lsb_done_d;
  logic          ic_done_q, ic_done_d;

  logic [31:0]   mem_a_c;
  logic [7:0]    mem_dout_c;
  logic          mem_wr_c;
  logic          ic_valid_c;
  logic [31:0]   cur_addr;
  logic [1:0]    lane;
  logic          io_stall;
  logic          turn;

  function automatic logic [CW-1:0] size_to_n(
    input logic [1:0] sz
  );
    logic [CW-1:0] n;
    unique case (sz)
      2'b00:   n = CW'(1);
      2'b01:   n = CW'(2);
      default: n = CW'(4);
    endcase
    return n;
  endfunction

  function automatic logic [31:0] extend(
    input logic [31:0]   raw,
    input logic [CW-1:0] n,
    input logic          sg
  );
    logic [31:0] r;
    if (n == CW'(1))
      r = {{24{sg & raw[7]}}, raw[7:0]};
    else if (n == CW'(2))
      r = {{16{sg & raw[15]}}, raw[15:0]};
    else
      r = raw;
    return r;
  endfunction

  assign cur_addr = addr_q + 32'(cnt_q);
  assign lane     = cnt_q[1:0] - 2'd1;
  assign io_stall = (addr_q[17:16] == 2'b11)
                  && bus.io_buffer_full;
  // a done pulse blocks acceptance for one cycle
  assign turn     = lsb_done_q | ic_done_q;

  // next-state and RAM-side drive for the sequencer
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    nbytes_d   = nbytes_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    buf_d      = buf_q;
    rdata_d    = rdata_q;
    signed_d   = signed_q;
    lsb_done_d = 1'b0;
    ic_done_d  = 1'b0;
    mem_a_c    = '0;
    mem_dout_c = '0;
    mem_wr_c   = 1'b0;
    ic_valid_c = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!turn) begin
          if (bus.lsb_req) begin
            state_d  = bus.lsb_wr ? S_LSB_WR
                                  : S_LSB_RD;
            cnt_d    = '0;
            addr_d   = bus.lsb_addr;
            wdata_d  = bus.lsb_wdata;
            nbytes_d = size_to_n(bus.lsb_size);
            signed_d = bus.lsb_signed;
            buf_d    = '0;
          end else if (bus.ic_req
                       && !bus.flush_in) begin
            state_d = S_IC_FILL;
            cnt_d   = '0;
            addr_d  = bus.ic_addr
                    & ~32'(LINE_BYTES - 1);
          end
        end
      end
      S_LSB_RD: begin
        if (cnt_q < nbytes_q)
          mem_a_c = cur_addr;
        if (cnt_q != '0)
          buf_d[{lane, 3'b000} +: 8] = bus.mem_din;
        if (cnt_q == nbytes_q) begin
          state_d    = S_IDLE;
          cnt_d      = '0;
          lsb_done_d = 1'b1;
          rdata_d    = extend(buf_d, nbytes_q,
                              signed_q);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_LSB_WR: begin
        if (!io_stall) begin
          mem_wr_c   = 1'b1;
          mem_a_c    = cur_addr;
          mem_dout_c =
            wdata_q[{cnt_q[1:0], 3'b000} +: 8];
          if (cnt_q == nbytes_q - CW'(1)) begin
            state_d    = S_IDLE;
            cnt_d      = '0;
            lsb_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_IC_FILL: begin
        ic_valid_c = (cnt_q != '0);
        if (cnt_q < LINE_CNT)
          mem_a_c = cur_addr;
        if (bus.flush_in) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == LINE_CNT) begin
          state_d   = S_IDLE;
          cnt_d     = '0;
          ic_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // state registers; reset clears everything incl. load data
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      nbytes_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      buf_q      <= '0;
      rdata_q    <= '0;
      signed_q   <= 1'b0;
      lsb_done_q <= 1'b0;
      ic_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      nbytes_q   <= nbytes_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      buf_q      <= buf_d;
      rdata_q    <= rdata_d;
      signed_q   <= signed_d;
      lsb_done_q <= lsb_done_d;
      ic_done_q  <= ic_done_d;
    end
  end

  assign bus.mem_a         = mem_a_c;
  assign bus.mem_dout      = mem_dout_c;
  assign bus.mem_wr        = mem_wr_c;
  assign bus.lsb_done      = lsb_done_q;
  assign bus.lsb_rdata     = rdata_q;
  assign bus.ic_done       = ic_done_q;
  assign bus.ic_byte_valid = ic_valid_c;
  assign bus.ic_byte       = ic_valid_c ? bus.mem_din
                                        : 8'h00;
  assign bus.ic_byte_idx   = ic_valid_c
                           ? IW'(cnt_q - CW'(1))
                           : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed steps with a scoreboard for RAM
// writes, fill bytes and LSB completions.
module tb_mem_arbiter;
  localparam int LB = 16;

  logic clk = 1'b0;
  logic rst_in;
  int   n_cmp = 0;
  int   n_err = 0;
  int   ic_done_cnt = 0;

  typedef struct {
    logic [31:0] a;
    logic [7:0]  d;
  } wr_t;
  typedef struct {
    logic [31:0] idx;
    logic [7:0]  b;
  } icb_t;

  wr_t         wq[$];
  icb_t        icq[$];
  logic [31:0] rq[$];

  mem_arbiter_if #(.LINE_BYTES(LB)) bus ();

  mem_arbiter #(.LINE_BYTES(LB)) dut (
    .clk_in(clk),
    .rst_in(rst_in),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(
    input logic [15:0] a
  );
    case (a)
      16'h0100: return 8'h78;
      16'h0101: return 8'h56;
      16'h0102: return 8'h34;
      16'h0103: return 8'h12;
      16'h0110: return 8'h80;
      16'h0120: return 8'h01;
      16'h0121: return 8'h80;
      16'hFFFE: return 8'h11;
      16'hFFFF: return 8'h22;
      16'h0000: return 8'h33;
      16'h0001: return 8'h44;
      default:  return a[7:0] ^ 8'h5A;
    endcase
  endfunction

  // RAM model: pattern contents overlaid by written bytes
  logic [7:0] wmem [0:65535];
  bit         wv   [0:65535];
  logic [7:0] din_q;
  always @(posedge clk) begin
    din_q <= wv[bus.mem_a[15:0]]
           ? wmem[bus.mem_a[15:0]]
           : init_val(bus.mem_a[15:0]);
    if (bus.mem_wr) begin
      wmem[bus.mem_a[15:0]] <= bus.mem_dout;
      wv[bus.mem_a[15:0]]   <= 1'b1;
    end
  end
  assign bus.mem_din = din_q;

  function automatic void chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endfunction

  // scoreboard pops on DUT output events
  always @(negedge clk) begin
    if (!rst_in) begin
      if (bus.mem_wr) begin
        chk("wr_pending", 32'(wq.size() != 0), 1);
        if (wq.size() != 0) begin
          wr_t e;
          e = wq.pop_front();
          chk("wr_addr", bus.mem_a, e.a);
          chk("wr_data", 32'(bus.mem_dout), 32'(e.d));
        end
      end
      if (bus.ic_byte_valid) begin
        chk("ic_pending", 32'(icq.size() != 0), 1);
        if (icq.size() != 0) begin
          icb_t e;
          e = icq.pop_front();
          chk("ic_idx", 32'(bus.ic_byte_idx), e.idx);
          chk("ic_byte", 32'(bus.ic_byte), 32'(e.b));
        end
      end
      if (bus.lsb_done) begin
        chk("rd_pending", 32'(rq.size() != 0), 1);
        if (rq.size() != 0)
          chk("rd_data", bus.lsb_rdata, rq.pop_front());
      end
      if (bus.lsb_done || bus.ic_done)
        chk("done_excl",
            32'(bus.lsb_done & bus.ic_done), 0);
      if (bus.ic_done)
        ic_done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(
    input logic [31:0] a,
    input logic [1:0]  sz,
    input logic        sg,
    input logic [31:0] exp,
    input string       tag
  );
    int n;
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    rq.push_back(exp);
    bus.lsb_req    = 1'b1;
    bus.lsb_wr     = 1'b0;
    bus.lsb_addr   = a;
    bus.lsb_size   = sz;
    bus.lsb_signed = sg;
    tick();
    for (int k = 0; k < n; k++) begin
      chk({tag, "_a"}, bus.mem_a, a + 32'(k));
      chk({tag, "_wr"}, 32'(bus.mem_wr), 0);
      tick();
    end
    chk({tag, "_early"}, 32'(bus.lsb_done), 0);
    tick();
    chk({tag, "_done"}, 32'(bus.lsb_done), 1);
    chk({tag, "_rd"}, bus.lsb_rdata, exp);
    bus.lsb_req = 1'b0;
    tick();
  endtask

  initial begin
    int t;
    rst_in             = 1'b1;
    bus.io_buffer_full = 1'b0;
    bus.flush_in       = 1'b0;
    bus.lsb_req        = 1'b0;
    bus.lsb_wr         = 1'b0;
    bus.lsb_addr       = '0;
    bus.lsb_size       = '0;
    bus.lsb_signed     = 1'b0;
    bus.lsb_wdata      = '0;
    bus.ic_req         = 1'b0;
    bus.ic_addr        = '0;
    tick();
    tick();
    chk("rst_a", bus.mem_a, 0);
    chk("rst_wr", 32'(bus.mem_wr), 0);
    chk("rst_rdata", bus.lsb_rdata, 0);
    chk("rst_done", 32'({bus.lsb_done, bus.ic_done}), 0);
    chk("rst_icv", 32'(bus.ic_byte_valid), 0);
    rst_in = 1'b0;
    tick();

    do_load(32'h100, 2'b10, 1'b0, 32'h12345678, "ldw");
    do_load(32'hFFFF_FFFE, 2'b10, 1'b0,
            32'h44332211, "wrap");
    do_load(32'h120, 2'b01, 1'b0, 32'h00008001, "ldh");

    // half store 0xBEEF to 0x200
    wq.push_back('{32'h200, 8'hEF});
    wq.push_back('{32'h201, 8'hBE});
    rq.push_back(32'h00008001);
    bus.lsb_req   = 1'b1;
    bus.lsb_wr    = 1'b1;
    bus.lsb_addr  = 32'h200;
    bus.lsb_size  = 2'b01;
    bus.lsb_wdata = 32'h0000BEEF;
    tick();
    chk("sth_c1", {bus.mem_a[23:0], bus.mem_dout},
        32'h000200EF);
    chk("sth_c1wr", 32'(bus.mem_wr), 1);
    tick();
    chk("sth_c2", {bus.mem_a[23:0], bus.mem_dout},
        32'h000201BE);
    tick();
    chk("sth_done", 32'(bus.lsb_done), 1);
    chk("sth_c3wr", 32'(bus.mem_wr), 0);
    bus.lsb_req = 1'b0;
    tick();
    do_load(32'h200, 2'b01, 1'b0, 32'h0000BEEF, "rbk");

    // IO byte store held off for three cycles
    wq.push_back('{32'h30000, 8'h5A});
    rq.push_back(32'h0000BEEF);
    bus.io_buffer_full = 1'b1;
    bus.lsb_req   = 1'b1;
    bus.lsb_wr    = 1'b1;
    bus.lsb_addr  = 32'h30000;
    bus.lsb_size  = 2'b00;
    bus.lsb_wdata = 32'h0000005A;
    for (int c = 1; c <= 3; c++) begin
      tick();
      chk("io_bub_wr", 32'(bus.mem_wr), 0);
      chk("io_bub_a", bus.mem_a, 0);
    end
    tick();
    bus.io_buffer_full = 1'b0;
    #1;
    chk("io_wr", 32'(bus.mem_wr), 1);
    chk("io_a", bus.mem_a, 32'h30000);
    tick();
    chk("io_done", 32'(bus.lsb_done), 1);
    bus.lsb_req = 1'b0;
    tick();

    // simultaneous requests: LSB first, then fill
    rq.push_back(32'hFFFFFF80);
    for (int i = 0; i < LB; i++)
      icq.push_back('{32'(i),
                     init_val(16'(32'h1000 + i))});
    bus.lsb_req    = 1'b1;
    bus.lsb_wr     = 1'b0;
    bus.lsb_addr   = 32'h110;
    bus.lsb_size   = 2'b00;
    bus.lsb_signed = 1'b1;
    bus.ic_req     = 1'b1;
    bus.ic_addr    = 32'h1004;
    tick();
    chk("prio_a", bus.mem_a, 32'h110);
    chk("prio_icv", 32'(bus.ic_byte_valid), 0);
    tick();
    tick();
    chk("prio_done", 32'(bus.lsb_done), 1);
    bus.lsb_req = 1'b0;
    tick();
    chk("turn_a", bus.mem_a, 0);
    tick();
    for (int c = 1; c <= LB; c++) begin
      chk("fill_a", bus.mem_a, 32'h1000 + 32'(c - 1));
      chk("fill_v", 32'(bus.ic_byte_valid),
          32'(c >= 2));
      tick();
    end
    chk("fill_last", {31'(bus.ic_byte_idx),
        bus.ic_byte_valid}, {31'(LB - 1), 1'b1});
    chk("fill_last_a", bus.mem_a, 0);
    tick();
    chk("fill_done", 32'(bus.ic_done), 1);
    bus.ic_req = 1'b0;
    tick();
    chk("fill_cnt", 32'(ic_done_cnt), 1);

    // fill aborted by flush in its fifth cycle
    for (int i = 0; i < 4; i++)
      icq.push_back('{32'(i),
                     init_val(16'(32'h1000 + i))});
    bus.ic_req  = 1'b1;
    bus.ic_addr = 32'h1000;
    for (int c = 1; c <= 5; c++)
      tick();
    bus.flush_in = 1'b1;
    bus.ic_req   = 1'b0;
    tick();
    bus.flush_in = 1'b0;
    for (int c = 6; c <= 9; c++) begin
      chk("fl_v", 32'(bus.ic_byte_valid), 0);
      chk("fl_a", bus.mem_a, 0);
      chk("fl_done", 32'(bus.ic_done), 0);
      tick();
    end
    chk("fl_cnt", 32'(ic_done_cnt), 1);

    // fresh fill after the abort starts at idx 0
    for (int i = 0; i < LB; i++)
      icq.push_back('{32'(i),
                     init_val(16'(32'h1010 + i))});
    bus.ic_req  = 1'b1;
    bus.ic_addr = 32'h1013;
    t = 0;
    tick();
    while (!bus.ic_done && t < 40) begin
      tick();
      t++;
    end
    chk("fill2_done", 32'(bus.ic_done), 1);
    bus.ic_req = 1'b0;
    tick();

    // reset in the middle of a word store
    wq.push_back('{32'h300, 8'h0D});
    bus.lsb_req   = 1'b1;
    bus.lsb_wr    = 1'b1;
    bus.lsb_addr  = 32'h300;
    bus.lsb_size  = 2'b10;
    bus.lsb_wdata = 32'hCAFEF00D;
    tick();
    tick();
    rst_in      = 1'b1;
    bus.lsb_req = 1'b0;
    #1;
    chk("mrst_wr", 32'(bus.mem_wr), 0);
    chk("mrst_a", bus.mem_a, 0);
    chk("mrst_rdata", bus.lsb_rdata, 0);
    chk("mrst_done", 32'(bus.lsb_done), 0);
    tick();
    rst_in = 1'b0;
    tick();
    chk("post_done", 32'(bus.lsb_done), 0);
    do_load(32'h110, 2'b00, 1'b0, 32'h00000080, "ldb");

    tick();
    chk("wq_empty", 32'(wq.size()), 0);
    chk("icq_empty", 32'(icq.size()), 0);
    chk("rq_empty", 32'(rq.size()), 0);
    chk("ic_done_total", 32'(ic_done_cnt), 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequencing arbiter for the byte-wide main-memory port. Serialises multi-byte load/store requests from the Load Store Buffer and line-fill bursts from the instruction cache onto the single 8-bit RAM interface. Handles byte lane ordering (little-endian), sign/zero extension, IO write back-pressure and fill abort on flush. It sits between the LSB/ICache and the top-level RAM pins.

## Interface
- LINE_BYTES, 16, bytes per ICache fill burst; power of two, 4..64
- clk_in  input  1  clock
- rst_in  input  1  reset; asynchronous, active-high
- mem_din  input  8  RAM read data; valid the cycle after its address
- mem_dout  output  8  RAM write data
- mem_a  output  32  RAM address
- mem_wr  output  1  RAM write strobe
- io_buffer_full  input  1  IO write buffer full; stalls IO stores
- flush_in  input  1  pipeline flush; aborts an ICache fill
- lsb_req  input  1  LSB request; held with operands stable until lsb_done
- lsb_wr  input  1  1 = store, 0 = load
- lsb_addr  input  32  byte address of lowest byte
- lsb_size  input  2  00 byte, 01 half, 10 word, 11 treated as word
- lsb_signed  input  1  sign-extend loads (byte/half)
- lsb_wdata  input  32  store data, bytes from [7:0] upward
- lsb_done  output  1  one-cycle completion pulse
- lsb_rdata  output  32  extended load data; valid while lsb_done=1, held until next load completes
- ic_req  input  1  ICache fill request; held until ic_done or flush
- ic_addr  input  32  fill address; low log2(LINE_BYTES) bits ignored (forced 0)
- ic_byte  output  8  fill byte
- ic_byte_valid  output  1  ic_byte/ic_byte_idx valid this cycle
- ic_byte_idx  output  log2(LINE_BYTES)  byte offset within line
- ic_done  output  1  one-cycle pulse, fill complete

## Operation
- States: IDLE, LSB_RD, LSB_WR, IC_FILL. Byte counter cnt, N = 1/2/4 from lsb_size.
- IDLE: mem_a=0, mem_wr=0, mem_dout=0. On an edge with lsb_req=1 → LSB_RD/LSB_WR (LSB has priority). Else ic_req=1 and flush_in=0 → IC_FILL. Requests are not sampled at the edge ending a cycle where lsb_done or ic_done is 1 (one-cycle turnaround).
- No preemption: an LSB request arriving during IC_FILL waits for ic_done or abort.
- LSB_RD: issue lsb_addr+k, k=0..N-1, one per cycle. Capture mem_din into byte lane k one cycle later. After the last capture, drive lsb_done with lsb_rdata. Extension: lsb_signed ? sign : zero from bit 8N-1. Reads never stall, including IO.
- LSB_WR: drive mem_a=lsb_addr+k, mem_dout=lsb_wdata[8k+7:8k], mem_wr=1 for k=0..N-1. If lsb_addr[17:16]==2'b11 (IO) and io_buffer_full=1 in a cycle, that cycle is a bubble: mem_wr=0, mem_a=0, k not advanced.
- IC_FILL: issue base+k, k=0..LINE_BYTES-1. One cycle later present ic_byte=mem_din, ic_byte_idx=k, ic_byte_valid=1. ic_done is asserted in the cycle after the last byte.
- flush_in=1 sampled in IC_FILL → IDLE next cycle. No further ic_byte_valid, no ic_done, in-flight byte dropped. LSB states ignore flush_in.
- Address arithmetic is 32-bit wrapping (0xFFFFFFFF+1 = 0).

## Timing
- Cycle 1 = first cycle after the accepting edge. Addresses are on mem_a from cycle 1.
- Load of N bytes: addresses in cycles 1..N; lsb_done in cycle N+2. Byte=3, half=4, word=6 cycles after accept edge.
- Store of N bytes: writes in cycles 1..N, plus stall bubbles; lsb_done in cycle after last write.
- Fill: addresses in cycles 1..L; byte k valid in cycle k+2; ic_done in cycle L+2 with L=LINE_BYTES. Last byte valid in L+1.
- At most one of lsb_done/ic_done per cycle. mem_wr=1 only in LSB_WR.
- Reset (any time, asynchronous): state IDLE, cnt=0; all outputs 0, including lsb_rdata. An in-progress store may be partially written; no done pulse.

## Test plan
- Word load, RAM[0x100..0x103]=78 56 34 12, signed=0: lsb_done in cycle 6, lsb_rdata=0x12345678; mem_a 0x100..0x103 in cycles 1–4.
- Signed byte load of 0x80 → 0xFFFFFF80; unsigned half load of 0x8001 (bytes 01 80) → 0x00008001.
- Half store 0xBEEF to 0x200: cycles 1–2 mem_wr=1, (0x200,EF), (0x201,BE); lsb_done cycle 3; RAM readback matches.
- IO byte store to 0x30000 with io_buffer_full=1 for cycles 1–3: mem_wr=0 in 1–3, write in cycle 4, lsb_done cycle 5.
- ic_req and lsb_req in the same cycle: LSB served first. Fill of 0x1004 (L=16) starts at 0x1000 after the turnaround; bytes idx 0..15 in order; ic_done once.
- flush_in asserted in fill cycle 5: ic_byte_valid low from cycle 6, no ic_done, mem_a=0. A following ic_req starts a fresh fill from idx 0.
